dual_port_register_file: RTL and testbench

- General-purpose CPU register file with two symmetric independent ports, A and B.
- Each port has its own address, write enable, write data and read data.
- Each port can read or write any register every cycle.
- Sits in the decode/writeback path of the core; the word width and register address width come from the core configuration.

---
 rtl/dual_port_register_file_if.sv | 24 ++
 rtl/dual_port_register_file.sv | 51 +++++
 tb/tb_dual_port_register_file.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dual_port_register_file_if.sv
// Port A/B bundle for the dual-port register file: per-port address, write enable, write data and read data.
interface dual_port_register_file_if #(
  parameter int WORD_SIZE    = 32,
  parameter int REGADDR_SIZE = 5
);
  logic                    wen_a;
  logic [REGADDR_SIZE-1:0] addr_a;
  logic [WORD_SIZE-1:0]    din_a;
  logic [WORD_SIZE-1:0]    dout_a;
  logic                    wen_b;
  logic [REGADDR_SIZE-1:0] addr_b;
  logic [WORD_SIZE-1:0]    din_b;
  logic [WORD_SIZE-1:0]    dout_b;

  modport master (
    output wen_a, addr_a, din_a, wen_b, addr_b, din_b,
    input  dout_a, dout_b
  );

  modport slave (
    input  wen_a, addr_a, din_a, wen_b, addr_b, din_b,
    output dout_a, dout_b
  );
endinterface

// File: rtl/dual_port_register_file.sv
// Two-port CPU register file: combinational reads, writes land on the next clk edge, no backpressure.
// Optional REGFILE_ZERO_REG_EN hardwires register 0 to zero; port A wins same-address write conflicts.
module dual_port_register_file #(
  parameter int WORD_SIZE    = 32,
  parameter int REGADDR_SIZE = 5
) (
  input logic                      clk,
  input logic                      rst,
  dual_port_register_file_if.slave rf
);
  localparam int DEPTH = 1 << REGADDR_SIZE;

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic                 wa_ok;
  logic                 wb_ok;

  always_comb begin
    wa_ok = 1'b0;
    wb_ok = 1'b0;
`ifdef REGFILE_ZERO_REG_EN
    wa_ok = (rf.wen_a == 1'b1) && (rf.addr_a != '0);
    wb_ok = (rf.wen_b == 1'b1) && (rf.addr_b != '0);
`else
    wa_ok = (rf.wen_a == 1'b1);
    wb_ok = (rf.wen_b == 1'b1);
`endif
    // Same-address collision: port B's write is dropped so A's data lands
    if (wa_ok && (rf.addr_a == rf.addr_b))
      wb_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wa_ok)
        mem[rf.addr_a] <= rf.din_a;
      if (wb_ok)
        mem[rf.addr_b] <= rf.din_b;
    end
  end

`ifdef REGFILE_ZERO_REG_EN
  assign rf.dout_a = (rf.addr_a == '0) ? '0 : mem[rf.addr_a];
  assign rf.dout_b = (rf.addr_b == '0) ? '0 : mem[rf.addr_b];
`else
  assign rf.dout_a = mem[rf.addr_a];
  assign rf.dout_b = mem[rf.addr_b];
`endif
endmodule

// File: tb/tb_dual_port_register_file.sv
// Bench for dual_port_register_file: array model checked every cycle plus literal checks of the directed vectors.
module tb_dual_port_register_file;
  localparam int W = 32;
  localparam int A = 5;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dual_port_register_file_if #(.WORD_SIZE(W), .REGADDR_SIZE(A)) rf_if ();

  dual_port_register_file #(.WORD_SIZE(W), .REGADDR_SIZE(A)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if)
  );

  always #5 clk = ~clk;

  // Reference model: plain array, what the registers must contain.
  logic [W-1:0] model_mem [32];
  bit           model_known = 1'b0;

  function automatic logic [W-1:0] model_rd(input logic [A-1:0] ad);
    if (ZR && ad == 0) return '0;
    return model_mem[ad];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      model_known = 1'b1;
    end else begin
      logic a_hits;
      a_hits = rf_if.wen_a && !(ZR && rf_if.addr_a == 0);
      if (a_hits) model_mem[rf_if.addr_a] = rf_if.din_a;
      if (rf_if.wen_b && !(ZR && rf_if.addr_b == 0) && !(a_hits && rf_if.addr_b == rf_if.addr_a))
        model_mem[rf_if.addr_b] = rf_if.din_b;
    end
  end

  always @(negedge clk) begin
    if (model_known) begin
      checks++;
      if (rf_if.dout_a !== model_rd(rf_if.addr_a)) begin
        errors++;
        $display("FAIL model_dout_a addr=%0d got=%h exp=%h t=%0t", rf_if.addr_a, rf_if.dout_a, model_rd(rf_if.addr_a), $time);
      end
      checks++;
      if (rf_if.dout_b !== model_rd(rf_if.addr_b)) begin
        errors++;
        $display("FAIL model_dout_b addr=%0d got=%h exp=%h t=%0t", rf_if.addr_b, rf_if.dout_b, model_rd(rf_if.addr_b), $time);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Inputs change just after a rising edge and are consumed by the following edge.
  task automatic drive(input logic r, input logic wa, input logic [A-1:0] aa, input logic [W-1:0] da,
                       input logic wb, input logic [A-1:0] ab, input logic [W-1:0] db);
    @(posedge clk);
    #1;
    rst          = r;
    rf_if.wen_a  = wa;
    rf_if.addr_a = aa;
    rf_if.din_a  = da;
    rf_if.wen_b  = wb;
    rf_if.addr_b = ab;
    rf_if.din_b  = db;
    #2;
  endtask

  initial begin
    rf_if.wen_a = 1'b0; rf_if.addr_a = '0; rf_if.din_a = '0;
    rf_if.wen_b = 1'b0; rf_if.addr_b = '0; rf_if.din_b = '0;

    // Reset clears state
    drive(1, 0, 0, 0, 0, 1, 0);
    check("rst_a0", rf_if.dout_a, 32'h0);
    check("rst_b1", rf_if.dout_b, 32'h0);
    drive(1, 0, 31, 0, 0, 31, 0);
    check("rst_a31", rf_if.dout_a, 32'h0);
    check("rst_b31", rf_if.dout_b, 32'h0);

    // Write then read register 0; old value visible until the edge
    drive(1, 1, 0, 32'hABCDEF00, 0, 0, 0);
    check("wr_pending_a", rf_if.dout_a, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("wr_read_a", rf_if.dout_a, ZR ? 32'h0 : 32'hABCDEF00);
    check("wr_read_b", rf_if.dout_b, ZR ? 32'h0 : 32'hABCDEF00);

    // Overwrite seen from port B
    drive(1, 1, 0, 32'hABCDEF01, 0, 0, 0);
    check("ovw_before_b", rf_if.dout_b, ZR ? 32'h0 : 32'hABCDEF00);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("ovw_after_b", rf_if.dout_b, ZR ? 32'h0 : 32'hABCDEF01);

    // Populate a nonzero register, then reset mid-operation with a competing write
    drive(1, 1, 3, 32'hCAFEF00D, 0, 3, 0);
    drive(0, 1, 0, 32'h12345678, 0, 3, 0);
    check("midrst_before_a", rf_if.dout_a, ZR ? 32'h0 : 32'hABCDEF01);
    check("midrst_before_b", rf_if.dout_b, 32'hCAFEF00D);
    drive(1, 0, 0, 0, 0, 3, 0);
    check("midrst_after_a", rf_if.dout_a, 32'h0);
    check("midrst_after_b", rf_if.dout_b, 32'h0);

    // Dual write to different addresses
    drive(1, 1, 5, 32'h11111111, 1, 6, 32'h22222222);
    drive(1, 0, 6, 0, 0, 5, 0);
    check("dual_a6", rf_if.dout_a, 32'h22222222);
    check("dual_b5", rf_if.dout_b, 32'h11111111);

    // Same-address conflict: A wins
    drive(1, 1, 7, 32'hAAAAAAAA, 1, 7, 32'hBBBBBBBB);
    drive(1, 0, 7, 0, 0, 7, 0);
    check("conflict_a", rf_if.dout_a, 32'hAAAAAAAA);
    check("conflict_b", rf_if.dout_b, 32'hAAAAAAAA);

    // Port B write visible on port A
    drive(1, 0, 0, 0, 1, 9, 32'h5A5A5A5A);
    drive(1, 0, 9, 0, 0, 31, 0);
    check("cross_b_to_a", rf_if.dout_a, 32'h5A5A5A5A);

    // Writes to register 0 from each port
    drive(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("zero_wr_a", rf_if.dout_a, ZR ? 32'h0 : 32'hFFFFFFFF);
    drive(1, 0, 0, 0, 1, 0, 32'h0F0F0F0F);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("zero_wr_b", rf_if.dout_a, ZR ? 32'h0 : 32'h0F0F0F0F);

    // Sweep: both ports write distinct patterns, then read everything back crosswise
    for (int i = 0; i < 16; i++)
      drive(1, 1, 5'(i), 32'h01010101 * i + 32'h10, 1, 5'(i + 16), ~(32'h00010001 * i));
    for (int i = 0; i < 32; i++)
      drive(1, 0, 5'(i), 0, 0, 5'(31 - i), 0);
    check("sweep_a31", rf_if.dout_a, ~(32'h00010001 * 15));
    check("sweep_b0", rf_if.dout_b, ZR ? 32'h0 : 32'h10);

    // Mixed traffic including conflicts, checked by the model each cycle
    for (int i = 0; i < 200; i++) begin
      logic [A-1:0] aa, ab;
      aa = 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 31));
      drive(1, 1'($urandom_range(0, 1)), aa, $urandom, 1'($urandom_range(0, 1)), ab, $urandom);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
